// File: rtl/cmb_mux_sched_pkg.sv
// Shared types and helpers for the mux scheduler slice.
package cmb_mux_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Settle counter width; it covers SETTLE values up to 15.
  localparam int CNT_W = 4;

  // Index width for n items, never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cmb_mux_sched_if.sv
// Request/response bundle between the requesters, the scheduler and the mux datapath.
interface cmb_mux_sched_if #(
  parameter int NREQ = 4,
  parameter int SELW = 4,
  parameter int DW   = 16
);
  localparam int IDW = cmb_mux_sched_pkg::clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*SELW-1:0] req_sel;
  logic [NREQ-1:0]      gnt;
  logic [SELW-1:0]      express;
  logic [DW-1:0]        mux_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 busy;

  // Requester / datapath side.
  modport master (
    output req, req_sel, mux_result, rsp_ready,
    input  gnt, express, rsp_valid, rsp_id, rsp_data, busy
  );

  // Scheduler side.
  modport slave (
    input  req, req_sel, mux_result, rsp_ready,
    output gnt, express, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/cmb_mux_sched_rr_pick.sv
// Combinational round-robin picker: first active request at or above the pointer, wrapping.
module cmb_mux_sched_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/cmb_mux_sched.sv
// Round-robin scheduler sharing one combinational mux between NREQ requesters.
//
// state  | meaning
// IDLE   | no transaction; arbitrate whenever any req is high
// SETTLE | select driven, counting down the settle time before capture
// RESP   | result captured, rsp_valid held until rsp_ready
module cmb_mux_sched
  import cmb_mux_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SELW   = 4,
  parameter int DW     = 16,
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  cmb_mux_sched_if.slave bus
);

  localparam int IDW = clog2(NREQ);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDW-1:0]    r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [SELW-1:0]   r_express;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic [DW-1:0]     r_rsp_data;

  logic [NREQ-1:0]   w_win_oh;
  logic [IDW-1:0]    w_win_idx;
  logic              w_any;
  logic [SELW-1:0]   w_win_sel;
  logic [IDW-1:0]    w_ptr_next;
  logic              w_accept;
  logic              w_arb;

  cmb_mux_sched_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_win_oh),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  assign w_win_sel  = bus.req_sel[int'(w_win_idx)*SELW +: SELW];
  assign w_ptr_next = (w_win_idx == IDW'(NREQ-1)) ? '0 : w_win_idx + 1'b1;
  assign w_accept   = r_rsp_valid && bus.rsp_ready;
  // Arbitration only from IDLE or on the response accept edge (back-to-back).
  assign w_arb      = (r_state == ST_IDLE) || ((r_state == ST_RESP) && w_accept);

  // Sequencer: grant, settle countdown, capture, and response hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_express   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= bus.mux_result;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (w_accept) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A new grant overrides the IDLE fall-back taken on an accept above.
      if (w_arb && w_any) begin
        r_gnt     <= w_win_oh;
        r_express <= w_win_sel;
        r_rsp_id  <= w_win_idx;
        r_cnt     <= CNT_W'(SETTLE - 1);
        r_ptr     <= w_ptr_next;
        r_state   <= ST_SETTLE;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.express   = r_express;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cmb_mux_sched.sv
// Bench for cmb_mux_sched: randomized requesters against a transaction-level model
// (SETTLE=1 instance) plus a directed settle-timing run on a SETTLE=3 instance.
module tb_cmb_mux_sched;
  import cmb_mux_sched_pkg::*;

  localparam int NREQ     = 4;
  localparam int SELW     = 4;
  localparam int DW       = 16;
  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 3;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  cmb_mux_sched_if #(.NREQ(NREQ), .SELW(SELW), .DW(DW)) bus_a ();
  cmb_mux_sched_if #(.NREQ(NREQ), .SELW(SELW), .DW(DW)) bus_b ();

  cmb_mux_sched #(.NREQ(NREQ), .SELW(SELW), .DW(DW), .SETTLE(SETTLE_A)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  cmb_mux_sched #(.NREQ(NREQ), .SELW(SELW), .DW(DW), .SETTLE(SETTLE_B)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: requesters, pointer, outstanding transaction.
  int              cyc;
  int              mode;
  logic [NREQ-1:0] m_req;
  logic [SELW-1:0] m_code [NREQ];
  int              m_ptr;
  bit              m_out;
  int              m_gcyc;
  int              m_gid;
  int              grant_due;
  int              due_id;
  logic [SELW-1:0] m_express;
  logic [DW-1:0]   mux_hist [0:4095];
  bit              rst_done;
  int              stall;

  task automatic raise(input int i, input logic [SELW-1:0] code);
    m_req[i]  = 1'b1;
    m_code[i] = code;
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One cycle: observe outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    logic [NREQ-1:0]      exp_gnt;
    logic [NREQ*SELW-1:0] sel;
    logic [DW-1:0]        mv;
    bit                   exp_valid;
    bit                   ready;
    bit                   accept;
    bit                   arb;
    bit                   do_rst;
    int                   just;
    @(negedge clk);
    exp_gnt = '0;
    just    = -1;
    do_rst  = 1'b0;
    if (grant_due == cyc) begin
      exp_gnt[due_id] = 1'b1;
      m_out     = 1'b1;
      m_gcyc    = cyc;
      m_gid     = due_id;
      m_express = m_code[due_id];
      m_req[due_id] = 1'b0;
      just      = due_id;
      m_ptr     = (due_id + 1) % NREQ;
      grant_due = -1;
    end
    chk("gnt", bus_a.gnt, exp_gnt);
    chk("express", bus_a.express, m_express);
    chk("busy", bus_a.busy, m_out);
    exp_valid = m_out && (cyc >= m_gcyc + SETTLE_A);
    chk("rsp_valid", bus_a.rsp_valid, exp_valid);
    if (exp_valid) begin
      chk("rsp_id", bus_a.rsp_id, m_gid);
      chk("rsp_data", bus_a.rsp_data, mux_hist[(m_gcyc + SETTLE_A - 1) & 4095]);
    end

    case (mode)
      1: if (cyc == 0) raise(2, 4'h5);
      2: for (int i = 0; i < NREQ; i++)
           if (!m_req[i] && i != just) raise(i, SELW'($urandom));
      3: for (int i = 0; i < NREQ; i++)
           if (!m_req[i] && i != just && $urandom_range(0, 2) == 0) raise(i, SELW'($urandom));
      4: begin
           if (!m_req[0] && just != 0) raise(0, SELW'($urandom));
           if (!m_req[3] && just != 3) raise(3, SELW'($urandom));
         end
      5: begin
           if (cyc == 110) raise(2, SELW'($urandom));
           if (just == 2 && !rst_done) begin
             do_rst   = 1'b1;
             rst_done = 1'b1;
             raise(1, SELW'($urandom));
             raise(3, SELW'($urandom));
           end
         end
      default: ;
    endcase

    ready = 1'b1;
    if (mode == 3) begin
      if (stall > 0) begin
        ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 7) == 0) begin
        ready = 1'b0;
        stall = 5;
      end else begin
        ready = ($urandom_range(0, 3) != 0);
      end
    end

    accept = exp_valid && ready;
    if (do_rst) begin
      m_out     = 1'b0;
      m_ptr     = 0;
      m_express = '0;
      grant_due = -1;
    end else begin
      arb = !m_out || accept;
      if (accept) m_out = 1'b0;
      if (arb && (m_req != '0)) begin
        due_id    = rr_winner(m_req, m_ptr);
        grant_due = cyc + 1;
      end
    end

    for (int i = 0; i < NREQ; i++) sel[i*SELW +: SELW] = m_code[i];
    mv = DW'($urandom);
    mux_hist[cyc & 4095] = mv;
    bus_a.req        = m_req;
    bus_a.req_sel    = sel;
    bus_a.rsp_ready  = ready;
    bus_a.mux_result = mv;
    rst_a            = do_rst;
    cyc++;
  endtask

  initial begin
    logic [DW-1:0] v3;
    bus_a.req = '0; bus_a.req_sel = '0; bus_a.rsp_ready = 1'b0; bus_a.mux_result = '0;
    bus_b.req = '0; bus_b.req_sel = '0; bus_b.rsp_ready = 1'b0; bus_b.mux_result = '0;
    m_req = '0;
    for (int i = 0; i < NREQ; i++) m_code[i] = '0;
    m_ptr = 0; m_out = 1'b0; m_gcyc = 0; m_gid = 0;
    grant_due = -1; due_id = 0; m_express = '0;
    rst_done = 1'b0; stall = 0; cyc = 0; mode = 0;

    repeat (3) @(negedge clk);
    chk("rst_gnt", bus_a.gnt, 0);
    chk("rst_express", bus_a.express, 0);
    chk("rst_valid", bus_a.rsp_valid, 0);
    chk("rst_id", bus_a.rsp_id, 0);
    chk("rst_data", bus_a.rsp_data, 0);
    chk("rst_busy", bus_a.busy, 0);

    for (int n = 0; n < 1170; n++) begin
      if      (n < 10)   mode = 1;
      else if (n < 40)   mode = 2;
      else if (n < 60)   mode = 0;
      else if (n < 90)   mode = 4;
      else if (n < 110)  mode = 0;
      else if (n < 130)  mode = 5;
      else if (n < 1130) mode = 3;
      else               mode = 0;
      step();
    end
    chk("rst_scenario_ran", rst_done, 1);

    // SETTLE=3 instance: select in cycle 1, capture at end of cycle 3, valid in cycle 4.
    @(negedge clk);
    rst_b = 1'b0;
    bus_b.req = 4'b0010;
    bus_b.req_sel = 16'h00A0;
    bus_b.rsp_ready = 1'b0;
    bus_b.mux_result = DW'($urandom);
    @(negedge clk);
    chk("b_gnt", bus_b.gnt, 4'b0010);
    chk("b_express", bus_b.express, 4'hA);
    chk("b_busy1", bus_b.busy, 1);
    bus_b.req = '0;
    bus_b.mux_result = DW'($urandom);
    @(negedge clk);
    chk("b_valid2", bus_b.rsp_valid, 0);
    chk("b_gnt2", bus_b.gnt, 0);
    bus_b.mux_result = DW'($urandom);
    @(negedge clk);
    chk("b_valid3", bus_b.rsp_valid, 0);
    v3 = DW'($urandom);
    bus_b.mux_result = v3;
    @(negedge clk);
    chk("b_valid4", bus_b.rsp_valid, 1);
    chk("b_data4", bus_b.rsp_data, v3);
    chk("b_id4", bus_b.rsp_id, 1);
    bus_b.mux_result = ~v3;
    bus_b.rsp_ready = 1'b1;
    @(negedge clk);
    chk("b_valid5", bus_b.rsp_valid, 0);
    chk("b_busy5", bus_b.busy, 0);
    chk("b_express5", bus_b.express, 4'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
